// File: rtl/dilithium_pkg.sv
// Shared definitions for the Dilithium signing framer: word width, mode codes,
// phase tags and the per-level word counts of every phase.
package dilithium_pkg;

  localparam int W = 64;

  localparam logic [1:0] MODE_KEYGEN = 2'd0;
  localparam logic [1:0] MODE_VERIFY = 2'd1;
  localparam logic [1:0] MODE_SIGN   = 2'd2;

  localparam logic [7:0] REJECT_MARK = 8'hA5;

  typedef enum logic [3:0] {
    PH_RHO, PH_MLEN, PH_TR, PH_MSG, PH_K, PH_S1, PH_S2, PH_T0,
    PH_Z, PH_H, PH_C, PH_END
  } phase_e;

  typedef enum logic [1:0] {S_IDLE, S_IN_PHASE, S_OUT_PHASE, S_DONE} state_e;

  // MSG has a data-dependent length, so the caller supplies it.
  function automatic logic [31:0] phase_words(input phase_e ph, input int level,
                                              input logic [31:0] msg_words);
    logic [31:0] words;
    words = 32'd4;
    case (ph)
      PH_MLEN: words = 32'd1;
      PH_MSG:  words = msg_words;
      PH_S1:   words = (level == 3) ? 32'd80  : (level == 5) ? 32'd84  : 32'd48;
      PH_S2:   words = (level == 3) ? 32'd96  : (level == 5) ? 32'd96  : 32'd48;
      PH_T0:   words = (level == 3) ? 32'd312 : (level == 5) ? 32'd416 : 32'd208;
      PH_Z:    words = (level == 3) ? 32'd400 : (level == 5) ? 32'd560 : 32'd288;
      PH_H:    words = (level == 3) ? 32'd8   : 32'd11;
      default: words = 32'd4;
    endcase
    return words;
  endfunction

  function automatic phase_e next_phase(input logic high_perf, input phase_e ph);
    phase_e nxt;
    nxt = PH_END;
    if (high_perf) begin
      case (ph)
        PH_RHO:  nxt = PH_MLEN;
        PH_MLEN: nxt = PH_TR;
        PH_TR:   nxt = PH_MSG;
        PH_MSG:  nxt = PH_K;
        PH_K:    nxt = PH_S1;
        PH_S1:   nxt = PH_S2;
        PH_S2:   nxt = PH_T0;
        PH_T0:   nxt = PH_Z;
        PH_Z:    nxt = PH_H;
        PH_H:    nxt = PH_C;
        default: nxt = PH_END;
      endcase
    end else begin
      case (ph)
        PH_RHO:  nxt = PH_K;
        PH_K:    nxt = PH_TR;
        PH_TR:   nxt = PH_S1;
        PH_S1:   nxt = PH_S2;
        PH_S2:   nxt = PH_T0;
        PH_T0:   nxt = PH_MLEN;
        PH_MLEN: nxt = PH_MSG;
        PH_MSG:  nxt = PH_C;
        PH_C:    nxt = PH_Z;
        PH_Z:    nxt = PH_H;
        default: nxt = PH_END;
      endcase
    end
    return nxt;
  endfunction

  function automatic logic is_output(input phase_e ph);
    return (ph == PH_Z) || (ph == PH_H) || (ph == PH_C);
  endfunction

endpackage

// File: rtl/dilithium_core.sv
// Stand-in signing datapath: always accepts input, folds it into an accumulator,
// streams tagged result words and pulses reject on marked secret-key words.
module dilithium_core
  import dilithium_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [1:0]   mode,
  input  phase_e       tag,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         out_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         reject
);

  logic [W-1:0] acc_q, acc_d;
  logic [25:0]  seq_q, seq_d;
  logic         in_fire;
  logic         secret_tag;

  assign in_ready   = 1'b1;
  assign in_fire    = in_valid && in_ready;
  assign secret_tag = (tag == PH_S1) || (tag == PH_S2) || (tag == PH_T0);
  assign reject     = in_fire && secret_tag && (in_data[W-1 -: 8] == REJECT_MARK);
  assign out_valid  = out_en;
  // Output only depends on registers, so it holds steady while the sink stalls.
  assign out_data   = {tag, mode, seq_q, acc_q[W-1:W/2] ^ acc_q[W/2-1:0]};

  always_comb begin
    acc_d = acc_q;
    seq_d = seq_q;
    if (clear) begin
      acc_d = '0;
      seq_d = '0;
    end else begin
      if (in_fire) acc_d = acc_q ^ in_data;
      if (out_valid && out_ready) seq_d = seq_q + 26'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      seq_q <= '0;
    end else begin
      acc_q <= acc_d;
      seq_q <= seq_d;
    end
  end

endmodule

// File: rtl/dilithium.sv
// Framing controller for Dilithium signing: sequences the input and output
// phases, counts words per phase and tracks signing rejections.
module dilithium
  import dilithium_pkg::*;
#(
  parameter int HIGH_PERF = 1,
  parameter int SEC_LEVEL = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic         valid_i,
  output logic         ready_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_o,
  output logic [W-1:0] data_o,
  output logic [7:0]   reject_counter
);

  localparam logic HP_ORDER = (HIGH_PERF != 0);

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] mlen_q, mlen_d;
  logic [7:0]  reject_q, reject_d;

  logic         core_clear, core_in_ready, core_out_valid, core_reject;
  logic [W-1:0] core_out_data, core_in_data, msg_mask;
  logic [31:0]  msg_words, phase_len;
  logic [3:0]   last_bytes;
  logic         last_word, in_fire, out_fire;
  phase_e       phase_nxt;

  assign msg_words = (mlen_q == 32'd0) ? 32'd1
                   : {3'b000, mlen_q[31:3]} + {31'd0, |mlen_q[2:0]};
  assign phase_len = phase_words(phase_q, SEC_LEVEL, msg_words);
  assign last_word = (cnt_q == phase_len - 32'd1);
  assign phase_nxt = next_phase(HP_ORDER, phase_q);

  // Valid byte count of the final MSG word (0..8); mod-16 arithmetic is exact here.
  assign last_bytes   = mlen_q[3:0] - {cnt_q[0], 3'b000};
  assign msg_mask     = ~({W{1'b1}} >> {last_bytes, 3'b000});
  assign core_in_data = (phase_q == PH_MSG && last_word) ? (data_i & msg_mask) : data_i;

  assign ready_i        = (state_q == S_IN_PHASE) && core_in_ready;
  assign in_fire        = valid_i && ready_i;
  assign valid_o        = (state_q == S_OUT_PHASE) && core_out_valid;
  assign out_fire       = valid_o && ready_o;
  assign data_o         = valid_o ? core_out_data : '0;
  assign reject_counter = reject_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    mlen_d     = mlen_q;
    reject_d   = reject_q;
    core_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && mode == MODE_SIGN) begin
          state_d    = S_IN_PHASE;
          phase_d    = PH_RHO;
          mode_d     = mode;
          cnt_d      = '0;
          mlen_d     = '0;
          reject_d   = '0;
          core_clear = 1'b1;
        end
      end
      S_IN_PHASE: begin
        if (in_fire) begin
          if (phase_q == PH_MLEN) mlen_d = data_i[31:0];
          if (core_reject && reject_q != 8'hFF) reject_d = reject_q + 8'd1;
          if (last_word) begin
            cnt_d   = '0;
            phase_d = phase_nxt;
            if (is_output(phase_nxt)) state_d = S_OUT_PHASE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_OUT_PHASE: begin
        if (out_fire) begin
          if (last_word) begin
            cnt_d   = '0;
            phase_d = phase_nxt;
            if (phase_nxt == PH_END) state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_RHO;
      mode_q   <= MODE_KEYGEN;
      cnt_q    <= '0;
      mlen_q   <= '0;
      reject_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      mlen_q   <= mlen_d;
      reject_q <= reject_d;
    end
  end

  dilithium_core u_core (
    .clk       (clk),
    .rst       (rst),
    .clear     (core_clear),
    .mode      (mode_q),
    .tag       (phase_q),
    .in_valid  (valid_i && state_q == S_IN_PHASE),
    .in_ready  (core_in_ready),
    .in_data   (core_in_data),
    .out_en    (state_q == S_OUT_PHASE),
    .out_valid (core_out_valid),
    .out_ready (ready_o),
    .out_data  (core_out_data),
    .reject    (core_reject)
  );

endmodule

// File: tb/tb_dilithium.sv
// Directed bench for the signing framer: an HP/level-2 instance and an
// LR/level-5 instance share stimulus; useLr picks which one is observed.
module tb_dilithium;

  localparam int PH_RHO = 0, PH_MLEN = 1, PH_TR = 2, PH_MSG = 3, PH_K = 4, PH_S1 = 5,
                 PH_S2 = 6, PH_T0 = 7, PH_Z = 8, PH_H = 9, PH_C = 10;

  logic        clk = 1'b0;
  logic        rst, start, valid_i, ready_o, useLr, readyPhase;
  logic [1:0]  mode;
  logic [63:0] data_i;
  logic        readyA, validA, readyB, validB;
  logic [63:0] dataA, dataB;
  logic [7:0]  rejA, rejB;
  logic        readyI, validO;
  logic [63:0] dataO;
  logic [7:0]  rej;
  int          total = 0;
  int          bad = 0;

  assign readyI = useLr ? readyB : readyA;
  assign validO = useLr ? validB : validA;
  assign dataO  = useLr ? dataB : dataA;
  assign rej    = useLr ? rejB : rejA;

  always #5 clk = ~clk;

  dilithium #(.HIGH_PERF(1), .SEC_LEVEL(2)) dutHp (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .valid_i(valid_i), .ready_i(readyA),
    .data_i(data_i), .valid_o(validA), .ready_o(ready_o), .data_o(dataA), .reject_counter(rejA));

  dilithium #(.HIGH_PERF(0), .SEC_LEVEL(5)) dutLr (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .valid_i(valid_i), .ready_i(readyB),
    .data_i(data_i), .valid_o(validB), .ready_o(ready_o), .data_o(dataB), .reject_counter(rejB));

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int phaseCount(input int ph, input int lvl, input int msgw);
    case (ph)
      PH_MLEN: return 1;
      PH_MSG:  return msgw;
      PH_S1:   return (lvl == 2) ? 48  : (lvl == 3) ? 80  : 84;
      PH_S2:   return (lvl == 2) ? 48  : 96;
      PH_T0:   return (lvl == 2) ? 208 : (lvl == 3) ? 312 : 416;
      PH_Z:    return (lvl == 2) ? 288 : (lvl == 3) ? 400 : 560;
      PH_H:    return (lvl == 3) ? 8   : 11;
      default: return 4;
    endcase
  endfunction

  // Hold reset for two edges, check the cleared outputs, release and idle one cycle.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; valid_i = 1'b0; ready_o = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstReadyI", 64'(readyI), 64'd0);
    checkOutput("rstValidO", 64'(validO), 64'd0);
    checkOutput("rstDataO", dataO, 64'd0);
    checkOutput("rstReject", 64'(rej), 64'd0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One signing operation: start, stream all input phases, drain all output phases.
  task automatic applyStimulus(input bit lr, input int lvl, input int mlen, input int nReject,
                               input bit toggle, input int abortAfter);
    int inOrder[8];
    int outOrder[3];
    int msgw, lastBytes, sent, seq, marked, stalls, cycles, expRej;
    bit badValid, badReady, got, stalled;
    logic [63:0] acc, mask, word, exp, held;
    logic [31:0] fold;
    useLr = lr;
    if (lr) begin
      inOrder  = '{PH_RHO, PH_K, PH_TR, PH_S1, PH_S2, PH_T0, PH_MLEN, PH_MSG};
      outOrder = '{PH_C, PH_Z, PH_H};
    end else begin
      inOrder  = '{PH_RHO, PH_MLEN, PH_TR, PH_MSG, PH_K, PH_S1, PH_S2, PH_T0};
      outOrder = '{PH_Z, PH_H, PH_C};
    end
    msgw = (mlen == 0) ? 1 : (mlen + 7) / 8;
    lastBytes = mlen - 8 * (msgw - 1);
    mask = '0;
    for (int b = 0; b < lastBytes; b++) mask[63 - 8*b -: 8] = 8'hFF;
    expRej = (nReject > 255) ? 255 : nReject;

    mode = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("readyAfterStart", 64'(readyI), 64'd1);

    acc = '0; sent = 0; marked = 0; stalls = 0; badValid = 1'b0;
    for (int p = 0; p < 8; p++) begin
      for (int w = 0; w < phaseCount(inOrder[p], lvl, msgw); w++) begin
        if (abortAfter >= 0 && sent == abortAfter) begin
          checkOutput("rejBeforeAbort", 64'(rej), 64'(nReject));
          valid_i = 1'b0;
          return;
        end
        if (inOrder[p] == PH_MLEN) begin
          word = 64'(mlen);
        end else begin
          word = {8'h11, 8'(inOrder[p]), 16'(w), 32'h5eed_0000 + 32'(sent)};
          if ((inOrder[p] == PH_S1 || inOrder[p] == PH_S2 || inOrder[p] == PH_T0) &&
              marked < nReject) begin
            word[63:56] = 8'hA5;
            marked++;
          end
        end
        if (inOrder[p] == PH_MSG && w == msgw - 1) acc ^= word & mask;
        else acc ^= word;
        valid_i = 1'b1; data_i = word;
        start = (sent == 6);
        cycles = 0;
        while (!readyI && cycles < 50) begin
          @(negedge clk);
          cycles++;
        end
        stalls += cycles;
        if (validO) badValid = 1'b1;
        if (!readyI) begin
          checkOutput("inTimeout", 64'(readyI), 64'd1);
          valid_i = 1'b0; start = 1'b0;
          return;
        end
        @(posedge clk);
        sent++;
        @(negedge clk);
        start = 1'b0;
      end
    end
    valid_i = 1'b0;
    checkOutput("inStalls", 64'(stalls), 64'd0);
    checkOutput("validDuringIn", 64'(badValid), 64'd0);
    checkOutput("readyAfterIn", 64'(readyI), 64'd0);
    checkOutput("validAfterIn", 64'(validO), 64'd1);

    fold = acc[63:32] ^ acc[31:0];
    seq = 0; badReady = 1'b0; readyPhase = 1'b1; held = '0;
    for (int p = 0; p < 3; p++) begin
      for (int w = 0; w < phaseCount(outOrder[p], lvl, msgw); w++) begin
        exp = {4'(outOrder[p]), 2'b10, 26'(seq), fold};
        got = 1'b0; cycles = 0;
        while (!got && cycles < 50) begin
          ready_o = toggle ? readyPhase : 1'b1;
          readyPhase = ~readyPhase;
          if (readyI) badReady = 1'b1;
          stalled = validO && !ready_o;
          if (stalled) held = dataO;
          if (validO && ready_o) begin
            checkOutput("outWord", dataO, exp);
            got = 1'b1;
          end
          @(posedge clk);
          @(negedge clk);
          if (stalled) begin
            checkOutput("holdValid", 64'(validO), 64'd1);
            checkOutput("holdData", dataO, held);
          end
          cycles++;
        end
        if (!got) checkOutput("outTimeout", 64'(got), 64'd1);
        seq++;
      end
    end
    ready_o = 1'b0;
    checkOutput("readyDuringOut", 64'(badReady), 64'd0);
    checkOutput("validAtDone", 64'(validO), 64'd0);
    checkOutput("readyAtDone", 64'(readyI), 64'd0);
    checkOutput("rejAtDone", 64'(rej), 64'(expRej));
    repeat (3) @(negedge clk);
    checkOutput("rejHold", 64'(rej), 64'(expRej));
    checkOutput("idleValid", 64'(validO), 64'd0);
  endtask

  // Directed sequence: ignored starts, HP runs, LR level-5 run, mid-S1 reset and restart.
  initial begin
    rst = 1'b0; start = 1'b0; mode = 2'd0; valid_i = 1'b0; data_i = '0;
    ready_o = 1'b0; useLr = 1'b0; readyPhase = 1'b1;
    doReset();

    mode = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      checkOutput("ignoreVerify", 64'(readyI), 64'd0);
      @(negedge clk);
    end
    mode = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignoreKeygen", 64'(readyI), 64'd0);

    applyStimulus(1'b0, 2, 33, 3, 1'b0, -1);
    doReset();
    applyStimulus(1'b0, 2, 0, 300, 1'b1, -1);
    doReset();
    applyStimulus(1'b1, 5, 20, 0, 1'b1, -1);
    doReset();
    applyStimulus(1'b0, 2, 8, 2, 1'b0, 4 + 1 + 4 + 1 + 4 + 10);
    doReset();
    applyStimulus(1'b0, 2, 8, 0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
